line_engine_arbiter: RTL

- Shares one Bresenham line-drawing engine between two independent line requesters. Example requesters: the primitive/line controller and a future fill/rectangle unit.
- Round-robin arbitration; the grant is held for the whole draw.
- Generates the engine's draw_en/draw_done handshake, including the mandatory low gap between draws.
- Watchdog aborts a draw whose done never arrives, so neither requester can hang the pipeline.

---
 rtl/line_engine_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/line_engine_arbiter.sv
// rtl/line_engine_arbiter.sv - round-robin arbiter sharing one line engine between two requesters
module line_engine_arbiter #(
  parameter int COORD_W = 8,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 req0,
  input  logic [4*COORD_W-1:0] coord0,
  input  logic                 req1,
  input  logic [4*COORD_W-1:0] coord1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic                 err,
  output logic                 busy,
  output logic                 eng_draw_en,
  output logic [COORD_W-1:0]   eng_x0,
  output logic [COORD_W-1:0]   eng_y0,
  output logic [COORD_W-1:0]   eng_x1,
  output logic [COORD_W-1:0]   eng_y1,
  input  logic                 eng_draw_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAW    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [4*COORD_W-1:0] coord_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 owner_q;
  logic                 last_q;
  logic                 timed_q;
  logic                 winner;
  logic                 timeout_hit;
  logic                 in_draw;
  logic                 in_release;

  // On a tie the requester that was not served last wins; otherwise the lone requester.
  assign winner      = (req0 && req1) ? ~last_q : ~req0;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 || req1) state_d = DRAW;
      DRAW:    if (eng_draw_done || timeout_hit) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      coord_q <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      timed_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            owner_q <= winner;
            last_q  <= winner;
            coord_q <= winner ? coord1 : coord0;
            cnt_q   <= '0;
            timed_q <= 1'b0;
          end
        end
        DRAW: begin
          cnt_q <= cnt_q + 1'b1;
          // A done arriving on the last allowed cycle is a normal completion.
          if (!eng_draw_done && timeout_hit) timed_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_draw    = (state_q == DRAW);
  assign in_release = (state_q == RELEASE);

  assign gnt0        = in_draw && !owner_q;
  assign gnt1        = in_draw && owner_q;
  assign done0       = in_release && !owner_q;
  assign done1       = in_release && owner_q;
  assign err         = in_release && timed_q;
  assign busy        = in_draw || in_release;
  assign eng_draw_en = in_draw;

  assign eng_x0 = in_draw ? coord_q[0*COORD_W +: COORD_W] : '0;
  assign eng_y0 = in_draw ? coord_q[1*COORD_W +: COORD_W] : '0;
  assign eng_x1 = in_draw ? coord_q[2*COORD_W +: COORD_W] : '0;
  assign eng_y1 = in_draw ? coord_q[3*COORD_W +: COORD_W] : '0;

endmodule
